// File: rtl/pc_gen_btb.sv
// pc_gen_btb: fetch PC generator with a direct-mapped branch target buffer.
// Next-pc selection is reset > trap > EX redirect > stall > BTB prediction > pc+4.
// The BTB is looked up combinationally on the registered pc. It is written one
// cycle after a resolved control transfer is presented on the upd_* port.
module pc_gen_btb #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = 32'h0000_0000,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            ex_redirect_valid,
  input  logic [XLEN-1:0] ex_redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  // Fetch address state
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_next;

  // BTB storage: valid, tag, word-address target, 2-bit saturating counter
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
  logic [XLEN-3:0]        target_q [BTB_ENTRIES];
  logic [XLEN-3:0]        target_d [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [1:0]             ctr_d    [BTB_ENTRIES];

  // Lookup side (registered pc)
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;
  logic [XLEN-1:0]  lk_target;

  // Update side (resolved branch address)
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       up_ctr;

  // Low address bits of the update port never reach the BTB
  logic unused_bits;
  assign unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[XLEN-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX_W+2];

  // BTB lookup against the current fetch address; sees pre-update contents
  always_comb begin
    lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken  = lk_hit && ctr_q[lk_idx][1];
    lk_target = lk_taken ? {target_q[lk_idx], 2'b00} : '0;
  end

  assign pc          = pc_q;
  assign pred_taken  = lk_taken;
  assign pred_target = lk_target;

  // Next fetch address, word aligned
  always_comb begin
    if (rst) begin
      pc_next = RESET_VEC;
    end else if (trap_valid) begin
      pc_next = trap_vec;
    end else if (ex_redirect_valid) begin
      pc_next = ex_redirect_pc;
    end else if (stall) begin
      pc_next = pc_q;
    end else if (lk_taken) begin
      pc_next = lk_target;
    end else begin
      pc_next = pc_q + XLEN'(4);
    end
    pc_d = {pc_next[XLEN-1:2], 2'b00};
  end

  // BTB training: counter update on hit, allocate on taken miss, reset clears valid
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr   = ctr_q[up_idx];
    if (rst) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (up_ctr != 2'b11) begin
            ctr_d[up_idx] = up_ctr + 2'd1;
          end
          target_d[up_idx] = upd_target[XLEN-1:2];
        end else if (up_ctr != 2'b00) begin
          ctr_d[up_idx] = up_ctr - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target[XLEN-1:2];
        ctr_d[up_idx]    = 2'b10;
      end
    end
  end

  // State registers; reset handling is folded into the next-state logic
  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    valid_q  <= valid_d;
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end

endmodule

// File: doc/pc_gen_btb.md
PC_GEN_BTB -- requirements
Module: pc_gen_btb

Interface
Parameters:
REQ-001 The block SHALL have parameter XLEN, default 32, giving the PC and target width.
REQ-002 The block SHALL have parameter RESET_VEC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-003 The block SHALL have parameter BTB_ENTRIES, default 16, giving the branch target buffer depth (power of two, 2..256).
REQ-004 The block SHALL define IDX_W = log2(BTB_ENTRIES) and TAG_W = XLEN-2-IDX_W as derived widths.
Ports:
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stall  in  1  hold current pc (fetch backpressure).
REQ-008 trap_valid  in  1  trap/exception redirect request.
REQ-009 trap_vec  in  XLEN  trap handler address.
REQ-010 ex_redirect_valid  in  1  EX-stage mispredict redirect request.
REQ-011 ex_redirect_pc  in  XLEN  corrected fetch address.
REQ-012 upd_valid  in  1  resolved control-transfer update for the BTB.
REQ-013 upd_pc  in  XLEN  address of the resolved branch/jump.
REQ-014 upd_taken  in  1  resolved direction.
REQ-015 upd_target  in  XLEN  resolved taken target.
REQ-016 pc  out  XLEN  current fetch address, registered.
REQ-017 pred_taken  out  1  BTB predicts the instruction at pc is taken.
REQ-018 pred_target  out  XLEN  predicted target; 0 when pred_taken=0.

Function
REQ-019 pc next-value priority SHALL be: rst > trap_valid > ex_redirect_valid > stall > pred_taken > pc+4.
REQ-020 trap_valid and ex_redirect_valid SHALL override stall in the same cycle.
REQ-021 Every value loaded into pc SHALL have bits [1:0] forced to 2'b00.
REQ-022 pc+4 SHALL wrap modulo 2^XLEN (e.g. FFFF_FFFC -> 0000_0000).
REQ-023 Each BTB entry SHALL hold valid(1), tag(TAG_W), target(XLEN-2, word address), and ctr(2-bit saturating).
REQ-024 Lookup SHALL be combinational on registered pc: index = pc[IDX_W+1:2], tag = pc[XLEN-1:IDX_W+2].
REQ-025 Hit SHALL be valid && tag match; pred_taken = hit && ctr[1]; pred_target = {target, 2'b00} when pred_taken, else 0.
REQ-026 On upd_valid, index/tag SHALL be taken from upd_pc; writes take effect at the next rising edge (same-cycle lookup sees old contents).
REQ-027 Update on hit: upd_taken -> ctr = min(ctr+1, 3) and target = upd_target[XLEN-1:2]; !upd_taken -> ctr = max(ctr-1, 0), target unchanged.
REQ-028 Update on miss with upd_taken: allocate valid=1, new tag, target, ctr=2'b10 (replaces any aliasing entry).
REQ-029 Update on miss with !upd_taken: no BTB change.
REQ-030 BTB updates SHALL proceed regardless of stall, trap_valid, or ex_redirect_valid.
REQ-031 Simultaneous update and lookup of the same index SHALL return pre-update data in that cycle.

Reset
REQ-032 When rst=1 at a rising edge, pc SHALL become RESET_VEC and every BTB valid bit SHALL clear; ctr and target contents are don't-care.
REQ-033 During rst, trap_valid, ex_redirect_valid, stall, and upd_valid SHALL be ignored, including an upd_valid arriving in the reset cycle.
REQ-034 In the cycle after reset, pred_taken=0 and pred_target=0.
REQ-035 Reset asserted mid-operation SHALL behave identically to power-on reset.

Verification
REQ-036 Reset then 3 idle cycles -> pc = 0, 4, 8, 0xC; pred_taken=0 throughout.
REQ-037 Hold stall=1 for 2 cycles at pc=0x10, then assert ex_redirect_valid=1 with ex_redirect_pc=0x103 while stall=1 -> pc holds 0x10 for 2 cycles, then becomes 0x100.
REQ-038 Assert trap_valid (trap_vec=0x80) and ex_redirect_valid (0x200) in the same cycle -> next pc=0x80.
REQ-039 Apply upd_valid with upd_pc=0x20, upd_taken=1, upd_target=0x40, then fetch reaches 0x20 -> pred_taken=1, pred_target=0x40, next pc=0x40.
REQ-040 Drive two not-taken updates to 0x20 after allocation (ctr 2->1->0) -> at pc=0x20, pred_taken=0 and next pc=0x24; one taken update (ctr=1) -> still not taken; a second -> taken.
REQ-041 With BTB_ENTRIES=16, allocate 0x20 then allocate 0x60 (same index, different tag) -> lookup at 0x20 misses; at pc=FFFF_FFFC with no hit, next pc=0.
